// File: rtl/stress_monitor.sv
// rtl/stress_monitor.sv - windowed stress-drop detector driving stressGezakt
// Optional: STRESS_SAT_ERR_EN flags an all-ones sample as a sensor fault.
module stress_monitor #(
    parameter int SAMPLE_W      = 8,
    parameter int WIN_LOG2      = 2,
    parameter int SETTLE_CYCLES = 8,
    parameter int THRESH        = 4,
    parameter int TIMEOUT       = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          A,
    input  logic [2:0]          F,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                stressGezakt,
    output logic                err
);

    localparam int ACC_W = SAMPLE_W + WIN_LOG2;
    localparam int CNT_W = WIN_LOG2 + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]    LAST_CNT    = CNT_W'((1 << WIN_LOG2) - 1);
    localparam logic [SET_W-1:0]    SETTLE_LOAD = SET_W'(SETTLE_CYCLES);
    localparam logic [TMO_W-1:0]    TMO_MAX     = TMO_W'(TIMEOUT);
    localparam logic [SAMPLE_W-1:0] THRESH_V    = SAMPLE_W'(THRESH);

    typedef enum logic [1:0] {SETTLE, ACCUM, COMPARE} state_t;

    state_t              state;
    state_t              state_next;
    logic [5:0]          af_q;
    logic                af_init;
    logic [SET_W-1:0]    settle_cnt;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;
    logic [SAMPLE_W-1:0] ref_avg;
    logic                have_ref;
    logic [TMO_W-1:0]    idle;

    logic                af_change;
    logic                accept;
    logic [SAMPLE_W-1:0] avg;
    logic                drop;
    logic                idle_hit;
    logic                sat_hit;

    // af_init keeps the very first capture after reset from looking like a change
    always_comb begin
        af_change = af_init && ({A, F} != af_q);
        accept    = (state == ACCUM) && sample_valid;
        avg       = acc[ACC_W-1:WIN_LOG2];
        drop      = have_ref && (ref_avg >= avg) && ((ref_avg - avg) >= THRESH_V);
        idle_hit  = (state == ACCUM) && !af_change && !sample_valid &&
                    (idle == TMO_MAX - TMO_W'(1));
`ifdef STRESS_SAT_ERR_EN
        sat_hit   = accept && !af_change && (sample == {SAMPLE_W{1'b1}});
`else
        sat_hit   = 1'b0;
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            SETTLE:  if (settle_cnt == SET_W'(1)) state_next = ACCUM;
            ACCUM:   if (accept && cnt == LAST_CNT) state_next = COMPARE;
            COMPARE: state_next = ACCUM;
            default: state_next = SETTLE;
        endcase
        if (af_change) state_next = SETTLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SETTLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            af_q         <= '0;
            af_init      <= 1'b0;
            settle_cnt   <= SETTLE_LOAD;
            acc          <= '0;
            cnt          <= '0;
            ref_avg      <= '0;
            have_ref     <= 1'b0;
            idle         <= '0;
            stressGezakt <= 1'b0;
            err          <= 1'b0;
        end else begin
            stressGezakt <= 1'b0;
            af_q         <= {A, F};
            af_init      <= 1'b1;
            if (idle_hit || sat_hit) err <= 1'b1;
            // a setpoint change wipes the partial window but keeps the reference
            if (af_change) begin
                settle_cnt <= SETTLE_LOAD;
                acc        <= '0;
                cnt        <= '0;
                idle       <= '0;
            end else begin
                case (state)
                    SETTLE: settle_cnt <= settle_cnt - SET_W'(1);
                    ACCUM: begin
                        if (accept) begin
                            acc  <= acc + ACC_W'(sample);
                            cnt  <= cnt + CNT_W'(1);
                            idle <= '0;
                        end else if (idle != TMO_MAX) begin
                            idle <= idle + TMO_W'(1);
                        end
                    end
                    COMPARE: begin
                        stressGezakt <= drop;
                        ref_avg      <= avg;
                        have_ref     <= 1'b1;
                        acc          <= '0;
                        cnt          <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stress_monitor.sv
// tb/tb_stress_monitor.sv - scoreboard bench for stress_monitor
module tb_stress_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] A = 3'd3;
    logic [2:0] F = 3'd1;
    logic       sample_valid = 1'b0;
    logic [7:0] sample = 8'd0;
    logic       stressGezakt;
    logic       err;

    int n_checks = 0;
    int n_fails  = 0;
    int edge_n   = 0;

    int m_ref  = 0;
    bit m_have = 1'b0;

    typedef struct { int e; logic v; } exp_t;
    exp_t sb[$];

`ifdef STRESS_SAT_ERR_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    stress_monitor dut (
        .clk          (clk),
        .reset        (reset),
        .A            (A),
        .F            (F),
        .sample_valid (sample_valid),
        .sample       (sample),
        .stressGezakt (stressGezakt),
        .err          (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n = edge_n + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (sb.size() > 0 && sb[0].e == edge_n) begin
                exp_t x;
                x = sb.pop_front();
                check("pulse", 32'(stressGezakt), 32'(x.v));
            end else if (stressGezakt) begin
                check("spurious_pulse", 32'(stressGezakt), 32'd0);
            end
        end
    end

    task automatic tick(input logic v, input logic [7:0] s);
        @(negedge clk);
        sample_valid = v;
        sample       = s;
    endtask

    task automatic tick_a(input logic [2:0] a, input logic v, input logic [7:0] s);
        @(negedge clk);
        A            = a;
        sample_valid = v;
        sample       = s;
    endtask

    // settle ticks present valid samples that must all be ignored
    task automatic settle_ticks();
        for (int i = 0; i < 8; i++) tick(1'b1, 8'd0);
    endtask

    task automatic window(input int s0, input int s1, input int s2, input int s3);
        int   vals[4];
        int   sum;
        int   avg;
        exp_t x;
        vals = '{s0, s1, s2, s3};
        sum  = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 8'(vals[i]));
            sum = sum + vals[i];
        end
        avg = sum / 4;
        x.e = edge_n + 2;
        x.v = m_have && (m_ref >= avg) && (m_ref - avg >= 4);
        sb.push_back(x);
        m_ref  = avg;
        m_have = 1'b1;
        tick(1'b1, 8'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        sample_valid = 1'b0;
        m_ref  = 0;
        m_have = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t x;
        repeat (3) @(negedge clk);
        check("reset_pulse", 32'(stressGezakt), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick(1'b0, 8'd0);

        // window comparison
        window(100, 100, 100, 100);
        window(90, 90, 90, 90);
        // threshold boundary
        window(100, 100, 100, 100);
        window(97, 97, 97, 97);
        window(93, 93, 93, 93);
        window(120, 120, 120, 120);

        // setpoint change mid-window
        window(100, 100, 100, 100);
        tick(1'b1, 8'd50);
        tick(1'b1, 8'd50);
        tick_a(3'd4, 1'b1, 8'd50);
        settle_ticks();
        window(80, 80, 80, 80);

        // setpoint change on the edge that would complete the window
        tick(1'b1, 8'd40);
        tick(1'b1, 8'd40);
        tick(1'b1, 8'd40);
        tick_a(3'd5, 1'b1, 8'd40);
        x.e = edge_n + 2;
        x.v = 1'b0;
        sb.push_back(x);
        settle_ticks();
        window(76, 76, 76, 76);

        // idle timeout
        repeat (63) tick(1'b0, 8'd0);
        @(negedge clk);
        check("err_before_timeout", 32'(err), 32'd0);
        @(negedge clk);
        check("err_at_timeout", 32'(err), 32'd1);
        window(70, 70, 70, 70);
        tick(1'b0, 8'd0);
        tick(1'b0, 8'd0);
        check("err_sticky", 32'(err), 32'd1);
        check("sb_drain_1", 32'(sb.size()), 32'd0);

        do_reset();
        #1;
        check("err_async_clear", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick(1'b0, 8'd0);

        // truncation: 43/4 -> 10, so 7 is a drop of only 3
        window(10, 11, 11, 11);
        window(7, 7, 7, 7);
        check("err_before_sat", 32'(err), 32'd0);
        window(255, 255, 255, 255);
        tick(1'b0, 8'd0);
        check("err_sat", 32'(err), 32'(SAT_EN));
        window(200, 200, 200, 200);
        tick(1'b0, 8'd0);
        tick(1'b0, 8'd0);
        check("sb_drain_2", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
